ps2_keyb_rx: RTL and testbench

PS/2 keyboard receiver. It sits between the clkps2/dataps2 board pins and the Sam Coupé keyboard matrix logic. It synchronises and deglitches the PS/2 lines, deserialises 11-bit device-to-host frames, and checks start, parity and stop bits. It folds the E0/F0 prefixes into flags, so downstream sees one pulse per key event carrying the scancode plus extended/released qualifiers.

---
 rtl/ps2_keyb_rx.sv | 177 +++++++++++++++++
 tb/tb_ps2_keyb_rx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ps2_keyb_rx.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit frame deserialiser with
// start/parity/stop checks, and E0/F0 prefix folding into key event qualifiers.
//
// state | meaning
// IDLE  | waiting for a start bit (fall with data low)
// RECV  | shifting in data, parity and stop bits; gap timer running
// CHECK | one cycle to validate the frame and publish the result
module ps2_keyb_rx #(
  parameter int CLKFREQ_KHZ = 12000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_US  = 1000
) (
  input  logic       clk12,
  input  logic       master_reset_n,
  input  logic       clkps2,
  input  logic       dataps2,
  output logic [7:0] scancode,
  output logic       extended,
  output logic       released,
  output logic       key_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TC = CLKFREQ_KHZ * TIMEOUT_US / 1000;
  localparam int TW = $clog2(TC + 1);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  state_t        state_q, state_d;
  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall_q, fall_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_pend_q, ext_pend_d, rel_pend_q, rel_pend_d;
  logic [7:0]    scancode_q, scancode_d;
  logic          extended_q, extended_d, released_q, released_d;
  logic          key_valid_q, key_valid_d, frame_err_q, frame_err_d;

  always_comb begin
    clk_s1_d    = clkps2;
    clk_s2_d    = clk_s1_q;
    dat_s1_d    = dataps2;
    dat_s2_d    = dat_s1_q;

    // Level changes only after FILTER_LEN consecutive samples disagree with it.
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else                               fcnt_d = fcnt_q + FW'(1);
    end
    fall_d = filt_q & ~filt_d;

    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    tmo_d       = tmo_q;
    ext_pend_d  = ext_pend_q;
    rel_pend_d  = rel_pend_q;
    scancode_d  = scancode_q;
    extended_d  = extended_q;
    released_d  = released_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall_q) begin
          if (!dat_s2_q) begin
            state_d  = RECV;
            bitcnt_d = '0;
            tmo_d    = '0;
            shift_d  = '0;
          end else begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            rel_pend_d  = 1'b0;
          end
        end
      end
      RECV: begin
        if (fall_q) begin
          shift_d  = {dat_s2_q, shift_q[9:1]};
          tmo_d    = '0;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd9) state_d = CHECK;
        end else if (tmo_q == TW'(TC - 1)) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          ext_pend_d  = 1'b0;
          rel_pend_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
        // shift_q[8:0] = parity & data; odd parity means their XOR is 1.
        if ((^shift_q[8:0]) && shift_q[9]) begin
          if (shift_q[7:0] == 8'hE0) begin
            ext_pend_d = 1'b1;
          end else if (shift_q[7:0] == 8'hF0) begin
            rel_pend_d = 1'b1;
          end else begin
            scancode_d  = shift_q[7:0];
            extended_d  = ext_pend_q;
            released_d  = rel_pend_q;
            key_valid_d = 1'b1;
            ext_pend_d  = 1'b0;
            rel_pend_d  = 1'b0;
          end
        end else begin
          frame_err_d = 1'b1;
          ext_pend_d  = 1'b0;
          rel_pend_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk12 or negedge master_reset_n) begin
    if (!master_reset_n) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      fcnt_q      <= '0;
      fall_q      <= 1'b0;
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      tmo_q       <= '0;
      ext_pend_q  <= 1'b0;
      rel_pend_q  <= 1'b0;
      scancode_q  <= 8'h00;
      extended_q  <= 1'b0;
      released_q  <= 1'b0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      fall_q      <= fall_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      ext_pend_q  <= ext_pend_d;
      rel_pend_q  <= rel_pend_d;
      scancode_q  <= scancode_d;
      extended_q  <= extended_d;
      released_q  <= released_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign scancode  = scancode_q;
  assign extended  = extended_q;
  assign released  = released_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_keyb_rx.sv
// Bench for ps2_keyb_rx: directed and random PS/2 frames scored against a
// key-event model built from prefix/parity rules.
`timescale 1ns/1ps
module tb_ps2_keyb_rx;

  localparam int TC = 12000;

  logic       clk12 = 1'b0;
  logic       master_reset_n = 1'b0;
  logic       clkps2 = 1'b1;
  logic       dataps2 = 1'b1;
  logic [7:0] scancode;
  logic       extended, released, key_valid, frame_err, busy;

  ps2_keyb_rx dut (
    .clk12(clk12), .master_reset_n(master_reset_n),
    .clkps2(clkps2), .dataps2(dataps2),
    .scancode(scancode), .extended(extended), .released(released),
    .key_valid(key_valid), .frame_err(frame_err), .busy(busy)
  );

  always #41.667 clk12 = ~clk12;

  int cyc = 0;
  always @(posedge clk12) cyc <= cyc + 1;

  int kv_cnt = 0, fe_cnt = 0, kv_cyc = 0, fe_cyc = 0, dbl_cnt = 0;
  logic kv_prev = 1'b0, fe_prev = 1'b0;
  always @(negedge clk12) begin
    if (key_valid) begin kv_cnt <= kv_cnt + 1; kv_cyc <= cyc; end
    if (frame_err) begin fe_cnt <= fe_cnt + 1; fe_cyc <= cyc; end
    if ((key_valid && kv_prev) || (frame_err && fe_prev)) dbl_cnt <= dbl_cnt + 1;
    kv_prev <= key_valid;
    fe_prev <= frame_err;
  end

  int n_chk = 0, n_err = 0;
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: published key state plus pending prefix flags.
  logic [7:0] m_sc = 8'h00;
  logic       m_ext = 1'b0, m_rel = 1'b0, p_ext = 1'b0, p_rel = 1'b0;
  int         stop_cyc = 0;

  task automatic send_frame(input logic [7:0] b, input int bad, input int half, input int nbits);
    logic [10:0] fr;
    fr = {(bad == 2) ? 1'b0 : 1'b1, (~^b) ^ (bad == 1), b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk12);
      dataps2 = fr[i];
      repeat (half / 2) @(negedge clk12);
      clkps2 = 1'b0;
      stop_cyc = cyc;
      repeat (half) @(negedge clk12);
      clkps2 = 1'b1;
      repeat (half / 2) @(negedge clk12);
    end
    dataps2 = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] b, input int bad, input int half);
    int kv0, fe0, exp_kv, exp_fe;
    kv0 = kv_cnt; fe0 = fe_cnt; exp_kv = 0; exp_fe = 0;
    send_frame(b, bad, half, 11);
    repeat (20) @(negedge clk12);
    if (bad != 0) begin
      exp_fe = 1; p_ext = 1'b0; p_rel = 1'b0;
    end else if (b == 8'hE0) begin
      p_ext = 1'b1;
    end else if (b == 8'hF0) begin
      p_rel = 1'b1;
    end else begin
      exp_kv = 1; m_sc = b; m_ext = p_ext; m_rel = p_rel;
      p_ext = 1'b0; p_rel = 1'b0;
    end
    check_eq($sformatf("kv_count[%h]", b), kv_cnt - kv0, exp_kv);
    check_eq($sformatf("fe_count[%h]", b), fe_cnt - fe0, exp_fe);
    check_eq($sformatf("scancode[%h]", b), scancode, m_sc);
    check_eq($sformatf("extended[%h]", b), extended, m_ext);
    check_eq($sformatf("released[%h]", b), released, m_rel);
    if (exp_kv == 1) check_eq("kv_latency", kv_cyc - stop_cyc, 12);
    if (exp_fe == 1) check_eq("fe_latency", fe_cyc - stop_cyc, 12);
  endtask

  initial begin
    int kv0, fe0, r, bad;
    logic [7:0] b;
    repeat (5) @(negedge clk12);
    check_eq("rst_scancode", scancode, 8'h00);
    check_eq("rst_flags", {extended, released, key_valid, frame_err, busy}, 5'b0);
    master_reset_n = 1'b1;
    repeat (5) @(negedge clk12);

    run_frame(8'h1C, 0, 180);
    run_frame(8'hF0, 0, 40);
    run_frame(8'h1C, 0, 40);
    run_frame(8'h1C, 0, 40);
    run_frame(8'hE0, 0, 40);
    run_frame(8'hF0, 0, 40);
    run_frame(8'h75, 0, 40);
    run_frame(8'hE0, 0, 40);
    run_frame(8'hE0, 0, 40);
    run_frame(8'h6B, 0, 40);
    run_frame(8'hF0, 0, 40);
    run_frame(8'h1C, 1, 40);
    run_frame(8'h1C, 2, 40);
    run_frame(8'hAA, 0, 40);

    // Partial frame then silence: gap timer must abandon it.
    kv0 = kv_cnt; fe0 = fe_cnt;
    send_frame(8'h00, 0, 40, 5);
    repeat (20) @(negedge clk12);
    check_eq("busy_mid_frame", busy, 1'b1);
    for (int i = 0; i < TC + 1000 && fe_cnt == fe0; i++) @(negedge clk12);
    check_eq("timeout_fe", fe_cnt - fe0, 1);
    check_eq("timeout_latency", fe_cyc - stop_cyc, TC + 11);
    check_eq("timeout_busy", busy, 1'b0);
    check_eq("timeout_kv", kv_cnt - kv0, 0);
    p_ext = 1'b0; p_rel = 1'b0;
    run_frame(8'h29, 0, 40);

    // Short clock glitches with data high would be a framing error if accepted.
    kv0 = kv_cnt; fe0 = fe_cnt;
    for (int g = 0; g < 10; g++) begin
      @(negedge clk12);
      clkps2 = 1'b0;
      repeat ((g % 7) + 1) @(negedge clk12);
      clkps2 = 1'b1;
      repeat (20) @(negedge clk12);
    end
    check_eq("glitch_fe", fe_cnt - fe0, 0);
    check_eq("glitch_busy", busy, 1'b0);

    // Reset in the middle of a frame.
    run_frame(8'hE0, 0, 40);
    send_frame(8'h33, 0, 40, 5);
    @(negedge clk12);
    master_reset_n = 1'b0;
    repeat (3) @(negedge clk12);
    m_sc = 8'h00; m_ext = 1'b0; m_rel = 1'b0; p_ext = 1'b0; p_rel = 1'b0;
    check_eq("midrst_scancode", scancode, m_sc);
    check_eq("midrst_flags", {extended, released, key_valid, frame_err, busy}, 5'b0);
    master_reset_n = 1'b1;
    repeat (5) @(negedge clk12);
    run_frame(8'h1C, 0, 40);

    for (int k = 0; k < 14; k++) begin
      r = $urandom_range(0, 5);
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
      run_frame(b, bad, $urandom_range(20, 60));
    end

    check_eq("strobe_width", dbl_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
